// File: rtl/ntp_pkg.sv
// ntp_pkg -- shared definitions for the NTP sync controller slice.
//   NTP_W             : width of an NTP timestamp (32.32 fixed point)
//   DEF_SET_COMP      : default set compensation (one 1 us fraction step)
//   DEF_LOST_PERIODS  : default number of 16 s periods before sync is lost
//   set_state_e       : set FSM state encoding
package ntp_pkg;

    localparam int                NTP_W            = 64;
    localparam logic [NTP_W-1:0]  DEF_SET_COMP     = 64'd4295;
    localparam logic [7:0]        DEF_LOST_PERIODS = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2
    } set_state_e;

endpackage

// File: rtl/ntp_cap_chan.sv
// ntp_cap_chan -- one timestamp capture channel.
//   i_clk, i_rst : clock, async active-high reset
//   i_pulse      : capture event, samples i_ts this cycle
//   i_ack        : consumer acknowledge, clears o_vld when no pulse
//   i_ts         : live timestamp
//   o_ts         : captured timestamp
//   o_vld        : capture valid
//   o_ovr        : sticky overrun (unconsumed capture overwritten)
module ntp_cap_chan
    import ntp_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pulse,
    input  logic             i_ack,
    input  logic [NTP_W-1:0] i_ts,
    output logic [NTP_W-1:0] o_ts,
    output logic             o_vld,
    output logic             o_ovr
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ts  <= '0;
            o_vld <= 1'b0;
            o_ovr <= 1'b0;
        end else if (i_pulse) begin
            o_ts  <= i_ts;
            o_vld <= 1'b1;
            // A same-cycle ack consumes the old sample, so it is not lost.
            if (o_vld && !i_ack)
                o_ovr <= 1'b1;
        end else if (i_ack) begin
            o_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/ntp_sync_ctrl.sv
// ntp_sync_ctrl -- arbitrates host/network set requests onto the timestamp
// counter load port, captures timestamps per channel and tracks sync loss.
//   i_clk, i_rst                          : clock, async active-high reset
//   i_host_set_req/val, o_host_set_ack    : host set port (level req, ack pulse)
//   i_net_set_req/val,  o_net_set_ack     : network set port (lower priority)
//   o_ntp_set, o_ntp_set_sig              : load value and one-cycle strobe
//   i_ntp_get, i_ntp_sig                  : live timestamp, 16 s period pulse
//   i_cap_pulse, i_cap_ack                : per-channel capture event / ack
//   o_cap_ts, o_cap_vld, o_cap_ovr        : per-channel capture results
//   o_sync_lost                           : too many periods without a set
module ntp_sync_ctrl
    import ntp_pkg::*;
#(
    parameter logic [NTP_W-1:0] P_SET_COMP     = DEF_SET_COMP,
    parameter logic [7:0]       P_LOST_PERIODS = DEF_LOST_PERIODS,
    parameter int               P_NCAP         = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_host_set_req,
    input  logic [NTP_W-1:0]        i_host_set_val,
    output logic                    o_host_set_ack,
    input  logic                    i_net_set_req,
    input  logic [NTP_W-1:0]        i_net_set_val,
    output logic                    o_net_set_ack,
    output logic [NTP_W-1:0]        o_ntp_set,
    output logic                    o_ntp_set_sig,
    input  logic [NTP_W-1:0]        i_ntp_get,
    input  logic                    i_ntp_sig,
    input  logic [P_NCAP-1:0]       i_cap_pulse,
    input  logic [P_NCAP-1:0]       i_cap_ack,
    output logic [P_NCAP*NTP_W-1:0] o_cap_ts,
    output logic [P_NCAP-1:0]       o_cap_vld,
    output logic [P_NCAP-1:0]       o_cap_ovr,
    output logic                    o_sync_lost
);

    set_state_e state, state_nxt;
    logic       win_net;      // winner of the set in flight
    logic       accept;
    logic       accept_net;
    logic [7:0] period_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Strobe and acks decode straight from state so reset kills them at once.
    always_comb begin
        state_nxt      = state;
        o_ntp_set_sig  = 1'b0;
        o_host_set_ack = 1'b0;
        o_net_set_ack  = 1'b0;
        accept         = 1'b0;
        accept_net     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_host_set_req || i_net_set_req) begin
                    accept     = 1'b1;
                    accept_net = !i_host_set_req;   // host has priority
                    state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_ntp_set_sig = 1'b1;
                state_nxt     = ST_SETTLE;
            end
            ST_SETTLE: begin
                o_host_set_ack = !win_net;
                o_net_set_ack  = win_net;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Value is captured at acceptance; requester may drop req afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            win_net   <= 1'b0;
            o_ntp_set <= '0;
        end else if (accept) begin
            win_net   <= accept_net;
            o_ntp_set <= (accept_net ? i_net_set_val : i_host_set_val) + P_SET_COMP;
        end
    end

    // Periods since last completed set; clear in SETTLE beats a period pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            period_cnt <= '0;
        else if (state == ST_SETTLE)
            period_cnt <= '0;
        else if (i_ntp_sig && period_cnt != 8'hFF)
            period_cnt <= period_cnt + 8'd1;
    end

    assign o_sync_lost = (period_cnt >= P_LOST_PERIODS);

    for (genvar n = 0; n < P_NCAP; n++) begin : g_cap
        ntp_cap_chan u_chan (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_pulse (i_cap_pulse[n]),
            .i_ack   (i_cap_ack[n]),
            .i_ts    (i_ntp_get),
            .o_ts    (o_cap_ts[n*NTP_W +: NTP_W]),
            .o_vld   (o_cap_vld[n]),
            .o_ovr   (o_cap_ovr[n])
        );
    end

endmodule

// File: tb/tb_ntp_sync_ctrl.sv
// tb_ntp_sync_ctrl -- directed + randomized bench for ntp_sync_ctrl.
// A behavioural timestamp counter feeds i_ntp_get; set strobes and acks are
// logged by cycle number and compared against transaction-level expectations.
module tb_ntp_sync_ctrl;

    localparam int          NC   = 3;
    localparam logic [63:0] COMP = 64'd4295;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            host_req = 1'b0, net_req = 1'b0;
    logic [63:0]     host_val = '0, net_val = '0;
    logic            host_ack, net_ack;
    logic [63:0]     ntp_set;
    logic            ntp_set_sig;
    logic [63:0]     ntp_get;
    logic            ntp_sig = 1'b0;
    logic [NC-1:0]   cap_pulse = '0, cap_ack = '0;
    logic [NC*64-1:0] cap_ts;
    logic [NC-1:0]   cap_vld, cap_ovr;
    logic            sync_lost;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #10 clk = ~clk;

    ntp_sync_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_host_set_req(host_req), .i_host_set_val(host_val), .o_host_set_ack(host_ack),
        .i_net_set_req(net_req), .i_net_set_val(net_val), .o_net_set_ack(net_ack),
        .o_ntp_set(ntp_set), .o_ntp_set_sig(ntp_set_sig),
        .i_ntp_get(ntp_get), .i_ntp_sig(ntp_sig),
        .i_cap_pulse(cap_pulse), .i_cap_ack(cap_ack),
        .o_cap_ts(cap_ts), .o_cap_vld(cap_vld), .o_cap_ovr(cap_ovr),
        .o_sync_lost(sync_lost)
    );

    // Behavioural timestamp counter: free-running, loads on the strobe.
    logic [63:0] ctr;
    always @(posedge clk or posedge rst) begin
        if (rst)              ctr <= 64'h0000_1234_0000_0000;
        else if (ntp_set_sig) ctr <= ntp_set;
        else                  ctr <= ctr + 64'd1;
    end
    assign ntp_get = ctr;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: strobe (cycle, value) and ack (cycle, 0=host 1=net).
    typedef struct { int c; logic [63:0] v; } ev_t;
    ev_t strb_q[$];
    ev_t ack_q[$];
    ev_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (ntp_set_sig) begin mon_e.c = cyc; mon_e.v = ntp_set; strb_q.push_back(mon_e); end
            if (host_ack)    begin mon_e.c = cyc; mon_e.v = 64'd0;   ack_q.push_back(mon_e);  end
            if (net_ack)     begin mon_e.c = cyc; mon_e.v = 64'd1;   ack_q.push_back(mon_e);  end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t q_at(input ev_t q[$], input int i);
        ev_t e;
        e.c = -1;
        e.v = '1;
        if (i < q.size()) e = q[i];
        return e;
    endfunction

    task automatic chk_ev(input string tag, input ev_t e, input int c, input logic [63:0] v);
        chk(tag, {32'(e.c), e.v}, {32'(c), v});
    endtask

    // Present requests, run a bounded window; requesters drop on their ack.
    task automatic run_set(input logic h, input logic [63:0] hv, input logic n,
                           input logic [63:0] nv, input bit drop, output int c0);
        strb_q.delete();
        ack_q.delete();
        c0 = cyc;
        host_req = h; host_val = hv;
        net_req  = n; net_val  = nv;
        for (int i = 0; i < 8; i++) begin
            step();
            if (drop && i == 0) begin
                host_req = 1'b0; net_req = 1'b0;
                host_val = {$urandom, $urandom}; net_val = {$urandom, $urandom};
            end
            if (host_ack) host_req = 1'b0;
            if (net_ack)  net_req  = 1'b0;
        end
        host_req = 1'b0;
        net_req  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_req = 1'b0; net_req = 1'b0; ntp_sig = 1'b0;
        cap_pulse = '0; cap_ack = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [63:0] v1, v2, g1, g2, pre;
    logic [NC-1:0] ev, eo;
    logic [63:0]   ets [NC];
    int c0, nsig;

    initial begin
        // ---- reset state
        step();
        chk("rst_sig",  {ntp_set_sig, host_ack, net_ack}, 3'b000);
        chk("rst_set",  ntp_set, 64'd0);
        chk("rst_cap",  {cap_vld, cap_ovr, sync_lost}, '0);
        chk("rst_ts",   cap_ts, '0);
        rst = 1'b0;
        step();

        // ---- single host set
        run_set(1'b1, 64'h0000_0001_0000_0000, 1'b0, '0, 1'b0, c0);
        chk("h_nstrb", strb_q.size(), 1);
        chk_ev("h_strb", q_at(strb_q, 0), c0 + 1, 64'h0000_0001_0000_10C7);
        chk("h_nack",  ack_q.size(), 1);
        chk_ev("h_ack",  q_at(ack_q, 0), c0 + 2, 64'd0);
        chk("h_hold",  ntp_set, 64'h0000_0001_0000_10C7);

        // ---- host and net together: host first, net 3 cycles later
        v1 = {$urandom, $urandom};
        v2 = {$urandom, $urandom};
        run_set(1'b1, v1, 1'b1, v2, 1'b0, c0);
        chk("hn_nstrb", strb_q.size(), 2);
        chk_ev("hn_strb0", q_at(strb_q, 0), c0 + 1, v1 + COMP);
        chk_ev("hn_strb1", q_at(strb_q, 1), c0 + 4, v2 + COMP);
        chk("hn_nack",  ack_q.size(), 2);
        chk_ev("hn_ack0", q_at(ack_q, 0), c0 + 2, 64'd0);
        chk_ev("hn_ack1", q_at(ack_q, 1), c0 + 5, 64'd1);

        // ---- wrap
        run_set(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, 1'b0, c0);
        chk_ev("wrap", q_at(strb_q, 0), c0 + 1, 64'h0000_0000_0000_10C6);

        // ---- net alone, requester drops right after acceptance
        v1 = {$urandom, $urandom};
        run_set(1'b0, '0, 1'b1, v1, 1'b1, c0);
        chk_ev("drop_strb", q_at(strb_q, 0), c0 + 1, v1 + COMP);
        chk_ev("drop_ack",  q_at(ack_q, 0),  c0 + 2, 64'd1);

        // ---- reset during LOAD
        strb_q.delete();
        ack_q.delete();
        host_req = 1'b1;
        host_val = {$urandom, $urandom};
        step();
        chk("rl_sig_pre", ntp_set_sig, 1'b1);
        rst = 1'b1;
        #1;
        chk("rl_sig", {ntp_set_sig, host_ack, net_ack}, 3'b000);
        chk("rl_set", ntp_set, 64'd0);
        host_req = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rl_noev", strb_q.size() + ack_q.size(), 0);
        v1 = {$urandom, $urandom};
        run_set(1'b1, v1, 1'b0, '0, 1'b0, c0);
        chk_ev("rl_next_strb", q_at(strb_q, 0), c0 + 1, v1 + COMP);
        chk_ev("rl_next_ack",  q_at(ack_q, 0),  c0 + 2, 64'd0);

        // ---- capture around a set: LOAD sees old time, SETTLE sees new
        do_reset();
        step();
        v1 = {$urandom, $urandom};
        host_req = 1'b1; host_val = v1;
        step();                                  // LOAD
        cap_pulse = 3'b001;
        pre = ctr;
        step();                                  // SETTLE
        host_req = 1'b0;
        cap_pulse = 3'b010;
        step();
        cap_pulse = '0;
        chk("cap_load",   cap_ts[63:0],    pre);
        chk("cap_settle", cap_ts[127:64],  v1 + COMP);

        // ---- overrun, and pulse+ack without overrun
        do_reset();
        step();
        cap_pulse = 3'b010; g1 = ctr; step();
        cap_pulse = 3'b010; g2 = ctr; step();
        cap_pulse = '0;
        chk("ovr1",    {cap_vld[1], cap_ovr[1]}, 2'b11);
        chk("ovr1_ts", cap_ts[127:64], g2);
        cap_ack = 3'b010; step(); cap_ack = '0;
        chk("ack1",    {cap_vld[1], cap_ovr[1]}, 2'b01);
        cap_pulse = 3'b100; step();
        cap_ack = 3'b100; g1 = ctr; step();
        cap_pulse = '0; cap_ack = '0;
        chk("pa2",     {cap_vld[2], cap_ovr[2]}, 2'b10);
        chk("pa2_ts",  cap_ts[191:128], g1);

        // ---- sync lost after four periods, cleared by a set
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("lost_pre", sync_lost, 1'b0);
            ntp_sig = 1'b1; step(); ntp_sig = 1'b0;
            step();
        end
        chk("lost4", sync_lost, 1'b1);
        host_req = 1'b1; host_val = {$urandom, $urandom};
        step();                                  // LOAD
        chk("lost_load", sync_lost, 1'b1);
        ntp_sig = 1'b1;                          // period pulse in SETTLE
        step();                                  // SETTLE
        host_req = 1'b0;
        chk("lost_settle", {sync_lost, host_ack}, 2'b11);
        step();
        ntp_sig = 1'b0;
        chk("lost_clr", sync_lost, 1'b0);

        // ---- counter saturates rather than wrapping
        ntp_sig = 1'b1;
        for (int i = 0; i < 300; i++) step();
        ntp_sig = 1'b0;
        chk("lost_sat", sync_lost, 1'b1);

        // ---- randomized captures and period pulses
        do_reset();
        ev = '0; eo = '0;
        for (int n = 0; n < NC; n++) ets[n] = '0;
        nsig = 0;
        for (int i = 0; i < 200; i++) begin
            cap_pulse = NC'($urandom & $urandom);
            cap_ack   = NC'($urandom);
            ntp_sig   = ($urandom_range(0, 15) == 0);
            g1 = ctr;
            // Expected channel state after this cycle.
            for (int n = 0; n < NC; n++) begin
                if (cap_pulse[n]) begin
                    ets[n] = g1;
                    if (ev[n] && !cap_ack[n]) eo[n] = 1'b1;
                    ev[n] = 1'b1;
                end else if (cap_ack[n]) begin
                    ev[n] = 1'b0;
                end
            end
            if (ntp_sig) nsig++;
            step();
            chk("rnd_vld",  cap_vld, ev);
            chk("rnd_ovr",  cap_ovr, eo);
            chk("rnd_ts",   cap_ts, {ets[2], ets[1], ets[0]});
            chk("rnd_lost", sync_lost, (nsig >= 4));
        end
        cap_pulse = '0; cap_ack = '0; ntp_sig = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
